// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and the data path (LW/SW).
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-low reset
//   if_req/if_addr                fetch request (level) and address
//   if_rdata/if_ack               fetched word and one-cycle completion
//   dm_readmem/dm_writemem        data read/write request (level; write wins if both)
//   dm_addr/dm_wdata              data address and store data
//   dm_rdata/dm_ack               load data and one-cycle completion
//   mem_addr/mem_wdata            memory address and write data
//   mem_read/mem_write            memory strobes, level for the whole access
//   mem_rdata/mem_ready           memory read data and access completion
//   stall                         combinational pipeline stall
//   bus_error                     pulses with the ack of a timed-out access
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_readmem,
  input  logic              dm_writemem,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic              bus_error
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int unsigned WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DM_ACC = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_ack_q, if_ack_d;
  logic                dm_ack_q, dm_ack_d;
  logic                bus_error_q, bus_error_d;

  logic dm_req_c;
  logic starved_c;

  assign dm_req_c  = dm_readmem | dm_writemem;
  // Fetch has waited through STARVE_MAX data grants: it wins the next tie.
  assign starved_c = (starve_cnt_q >= STARVE_W'(STARVE_MAX));

  // Next-state, grant, completion and timeout logic.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = if_req ? starve_cnt_q : '0;
    wait_cnt_d   = wait_cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    bus_error_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dm_req_c && (!if_req || !starved_c)) begin
          state_d     = DM_ACC;
          wait_cnt_d  = '0;
          mem_addr_d  = dm_addr;
          mem_write_d = dm_writemem;
          mem_read_d  = ~dm_writemem;
          mem_wdata_d = dm_writemem ? dm_wdata : '0;
          if (if_req && !starved_c) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
          end
        end else if (if_req) begin
          state_d      = IF_ACC;
          wait_cnt_d   = '0;
          starve_cnt_d = '0;
          mem_addr_d   = if_addr;
          mem_write_d  = 1'b0;
          mem_read_d   = 1'b1;
          mem_wdata_d  = '0;
        end
      end

      IF_ACC, DM_ACC: begin
        if (mem_ready) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (state_q == IF_ACC) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = mem_write_q ? '0 : mem_rdata;
          end
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
          // Watchdog abort: ack with zero data and flag the error.
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          bus_error_d = 1'b1;
          if (state_q == IF_ACC) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end else begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      wait_cnt_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_ack_q     <= if_ack_d;
      dm_ack_q     <= dm_ack_d;
      bus_error_q  <= bus_error_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign bus_error = bus_error_q;

  // A requester stalls until its ack; the ack cycle itself lets it advance.
  assign stall = reset & ((if_req & ~if_ack_q) | (dm_req_c & ~dm_ack_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected acks and
// point checks into queues; one negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_readmem;
  logic        dm_writemem;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic        bus_error;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(16)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_readmem(dm_readmem), .dm_writemem(dm_writemem), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall(stall), .bus_error(bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        is_dm;
    logic [31:0] rdata;
    logic        berr;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  exp_t exp_q[$];
  chk_t chk_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic expect_ack(input logic is_dm, input logic [31:0] rdata, input logic berr);
    exp_t e;
    e.is_dm = is_dm;
    e.rdata = rdata;
    e.berr  = berr;
    exp_q.push_back(e);
  endtask

  // Monitor: drains point checks and matches every ack against the scoreboard.
  always @(negedge clock) begin
    chk_t        c;
    exp_t        e;
    logic [33:0] got;
    logic [33:0] want;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      n_cmp++;
      if (c.act !== c.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", c.name, c.act, c.exp);
      end
    end
    if (reset && (if_ack || dm_ack || bus_error)) begin
      n_cmp++;
      got = {dm_ack, bus_error, dm_ack ? dm_rdata : if_rdata};
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ack: got if_ack=%0b dm_ack=%0b bus_error=%0b expected none",
                 if_ack, dm_ack, bus_error);
      end else if (if_ack == dm_ack) begin
        n_err++;
        e = exp_q.pop_front();
        $display("FAIL ack_port: got if_ack=%0b dm_ack=%0b expected exactly one", if_ack, dm_ack);
      end else begin
        e = exp_q.pop_front();
        want = {e.is_dm, e.berr, e.rdata};
        if (got !== want) begin
          n_err++;
          $display("FAIL ack_payload: got {dm,berr,rdata}=%h expected %h", got, want);
        end
      end
    end
  end

  initial begin
    int          acks;
    int          grants;
    int          rd_cnt;
    int          wr_cnt;
    int          berr_cnt;
    logic        rd_seen;
    logic [9:0]  seq;

    reset       = 1'b0;
    if_req      = 1'b0;
    if_addr     = 32'h0;
    dm_readmem  = 1'b0;
    dm_writemem = 1'b0;
    dm_addr     = 32'h0;
    dm_wdata    = 32'h0;
    mem_rdata   = 32'h0;
    mem_ready   = 1'b0;

    // Reset with all requests high: everything stays 0.
    if_req = 1'b1; if_addr = 32'h40; dm_readmem = 1'b1; dm_addr = 32'h200;
    mem_rdata = 32'h9999_9999; mem_ready = 1'b1;
    repeat (3) tick();
    chk("rst_mem_read",  32'(mem_read),  32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_addr",  mem_addr,       32'h0);
    chk("rst_mem_wdata", mem_wdata,      32'h0);
    chk("rst_if_ack",    32'(if_ack),    32'h0);
    chk("rst_dm_ack",    32'(dm_ack),    32'h0);
    chk("rst_bus_error", 32'(bus_error), 32'h0);
    chk("rst_if_rdata",  if_rdata,       32'h0);
    chk("rst_dm_rdata",  dm_rdata,       32'h0);
    chk("rst_stall",     32'(stall),     32'h0);
    mem_ready = 1'b0;
    reset = 1'b1;
    tick();
    chk("post_rst_dm_first_read", 32'(mem_read),  32'h1);
    chk("post_rst_dm_first_wr",   32'(mem_write), 32'h0);
    chk("post_rst_dm_first_addr", mem_addr,       32'h200);
    chk("post_rst_stall",         32'(stall),     32'h1);
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    expect_ack(1'b1, 32'h1111_2222, 1'b0);
    tick();
    if_req = 1'b0; dm_readmem = 1'b0; mem_ready = 1'b0;
    repeat (2) tick();

    // Single fetch.
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    chk("fetch_mem_read", 32'(mem_read),  32'h1);
    chk("fetch_mem_wr",   32'(mem_write), 32'h0);
    chk("fetch_mem_addr", mem_addr,       32'h40);
    chk("fetch_stall_hi", 32'(stall),     32'h1);
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    expect_ack(1'b0, 32'hDEAD_BEEF, 1'b0);
    tick();
    chk("fetch_ack",       32'(if_ack),   32'h1);
    chk("fetch_stall_low", 32'(stall),    32'h0);
    chk("fetch_strobe_off", 32'(mem_read), 32'h0);
    if_req = 1'b0; mem_ready = 1'b0;
    repeat (2) tick();

    // Store with three wait cycles.
    dm_writemem = 1'b1; dm_addr = 32'h100; dm_wdata = 32'h1234_5678; mem_rdata = 32'hBAD0_BAD0;
    wr_cnt = 0; rd_seen = 1'b0; acks = 0;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (mem_write) begin
        wr_cnt++;
        chk("store_wdata", mem_wdata, 32'h1234_5678);
      end
      if (mem_read) rd_seen = 1'b1;
      if (dm_ack) begin
        acks++;
        dm_writemem = 1'b0;
      end
      if (wr_cnt == 1 && mem_write) expect_ack(1'b1, 32'h0, 1'b0);
      mem_ready = mem_write && (wr_cnt == 4);
      tick();
    end
    chk("store_write_cycles", 32'(wr_cnt),  32'd4);
    chk("store_no_read",      32'(rd_seen), 32'h0);
    chk("store_ack_count",    32'(acks),    32'd1);

    // Read and write together: treated as a write.
    dm_readmem = 1'b1; dm_writemem = 1'b1; dm_addr = 32'h104; dm_wdata = 32'hA0A0_A0A0;
    tick();
    chk("both_write", 32'(mem_write), 32'h1);
    chk("both_read",  32'(mem_read),  32'h0);
    chk("both_wdata", mem_wdata,      32'hA0A0_A0A0);
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    expect_ack(1'b1, 32'h0, 1'b0);
    tick();
    dm_readmem = 1'b0; dm_writemem = 1'b0; mem_ready = 1'b0;
    repeat (2) tick();

    // Starvation guard: D,D,D,D,I,D,D,D,D,I.
    for (int i = 0; i < 10; i++) expect_ack(((i % 5) != 4), 32'hCAFE_0000, 1'b0);
    if_req = 1'b1; if_addr = 32'h40; dm_readmem = 1'b1; dm_addr = 32'h200;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0000;
    acks = 0; grants = 0; seq = '0;
    for (int cyc = 0; cyc < 60 && acks < 10; cyc++) begin
      tick();
      if (mem_read) begin
        grants++;
        seq = {seq[8:0], (mem_addr == 32'h40)};
      end
      if (if_ack || dm_ack) acks++;
      if (acks == 10) begin
        if_req = 1'b0; dm_readmem = 1'b0;
      end
    end
    if_req = 1'b0; dm_readmem = 1'b0; mem_ready = 1'b0;
    repeat (2) tick();
    chk("starve_acks",   32'(acks),   32'd10);
    chk("starve_grants", 32'(grants), 32'd10);
    chk("starve_order",  32'(seq),    32'h021);

    // Watchdog timeout.
    dm_readmem = 1'b1; dm_addr = 32'h300; mem_rdata = 32'h7777_7777; mem_ready = 1'b0;
    expect_ack(1'b1, 32'h0, 1'b1);
    rd_cnt = 0; acks = 0; berr_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (mem_read) rd_cnt++;
      if (bus_error) berr_cnt++;
      if (dm_ack) begin
        acks++;
        chk("timeout_ack_after_strobes", 32'(rd_cnt), 32'd16);
        dm_readmem = 1'b0;
      end
    end
    chk("timeout_strobe_cycles", 32'(rd_cnt),   32'd16);
    chk("timeout_ack_count",     32'(acks),     32'd1);
    chk("timeout_berr_count",    32'(berr_cnt), 32'd1);
    chk("timeout_idle_read",     32'(mem_read), 32'h0);

    // mem_ready in the last permitted cycle completes normally.
    dm_readmem = 1'b1; dm_addr = 32'h304; mem_rdata = 32'h7777_7777; mem_ready = 1'b0;
    expect_ack(1'b1, 32'h7777_7777, 1'b0);
    rd_cnt = 0; acks = 0; berr_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (mem_read) rd_cnt++;
      if (bus_error) berr_cnt++;
      if (dm_ack) begin
        acks++;
        dm_readmem = 1'b0;
      end
      mem_ready = mem_read && (rd_cnt == 16);
    end
    mem_ready = 1'b0;
    chk("edge_strobe_cycles", 32'(rd_cnt),   32'd16);
    chk("edge_ack_count",     32'(acks),     32'd1);
    chk("edge_no_berr",       32'(berr_cnt), 32'd0);

    // Reset during an IF access: aborted silently, then re-granted.
    if_req = 1'b1; if_addr = 32'h80; mem_ready = 1'b0; mem_rdata = 32'h0BAD_0BAD;
    tick();
    chk("midrst_granted", 32'(mem_read), 32'h1);
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_read_off", 32'(mem_read), 32'h0);
    chk("midrst_no_ack",   32'(if_ack),   32'h0);
    chk("midrst_addr_clr", mem_addr,      32'h0);
    chk("midrst_stall",    32'(stall),    32'h0);
    reset = 1'b1;
    tick();
    chk("midrst_regrant_read", 32'(mem_read), 32'h1);
    chk("midrst_regrant_addr", mem_addr,      32'h80);
    mem_ready = 1'b1; mem_rdata = 32'h55AA_55AA;
    expect_ack(1'b0, 32'h55AA_55AA, 1'b0);
    tick();
    if_req = 1'b0; mem_ready = 1'b0;
    repeat (3) tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
